mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port Op  input  2  operation select: 00 MULLO, 01 MULHI, 10 DIV (quotient), 11 MOD (remainder).
REQ-005 SHALL have port Dest  input  3  destination register address for the result.
REQ-006 SHALL have port OperandA  input  8  first operand, from register file read port A.
REQ-007 SHALL have port OperandB  input  8  second operand, from register file read port B.
REQ-008 SHALL have port Busy  output  1  high while an accepted operation is in progress (CALC or WB).
REQ-009 SHALL have port Done  output  1  one-cycle pulse marking result write-back.
REQ-010 SHALL have port DivZero  output  1  high with Done when DIV or MOD had OperandB = 0.
REQ-011 SHALL have port WriteEN  output  1  register-file write enable.
REQ-012 SHALL have port Write_Address  output  3  register-file write address.
REQ-013 SHALL have port Write_Data  output  8  register-file write data.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, WB.
REQ-015 SHALL, in IDLE with Start=1 at a rising edge, capture OperandA, OperandB, Op and Dest into internal registers and enter CALC with the iteration counter at 0.
REQ-016 SHALL ignore Start in CALC and WB; the captured operands SHALL NOT change until the next accepted Start.
REQ-017 SHALL perform exactly one iteration per clock in CALC, for 8 iterations, then enter WB.
REQ-018 SHALL implement multiplication as unsigned 8x8 shift-add producing a 16-bit product; MULLO returns bits 7:0, MULHI returns bits 15:8.
REQ-019 SHALL implement division as unsigned 8-bit restoring division, one quotient bit per iteration, MSB first; DIV returns the quotient, MOD returns the remainder.
REQ-020 SHALL, for DIV or MOD with OperandB = 0, return quotient 8'hFF and remainder = OperandA, and assert DivZero in the WB cycle.
REQ-021 SHALL, in WB, assert WriteEN=1 and Done=1 for exactly one cycle, with Write_Address = captured Dest and Write_Data = the result, then return to IDLE.
REQ-022 SHALL drive WriteEN, Done and DivZero from registers, and SHALL drive Write_Address and Write_Data to 0 whenever WriteEN=0.
REQ-023 SHALL have fixed latency: Start accepted at edge E0; WriteEN/Done high between edges E8 and E9; state IDLE after E9; earliest next accepted Start at E10.
REQ-024 SHALL hold Busy=1 from after E0 through the WB cycle, and Busy=0 in IDLE.
REQ-025 SHALL have result timing that is independent of operand values, including zero and divide-by-zero.

Reset
REQ-026 SHALL, while RST=0, immediately force state IDLE, counter 0, all internal registers 0, and Busy=Done=DivZero=WriteEN=0, Write_Address=0, Write_Data=0.
REQ-027 SHALL, when RST is asserted mid-CALC or mid-WB, abort the operation with no write-back; after RST deasserts, the block SHALL accept a new Start normally.

Verification
REQ-028 SHALL verify MULLO, A=13, B=11, Dest=3 -> 9 cycles after the Start edge: one-cycle WriteEN, Write_Address=3, Write_Data=8'h8F, DivZero=0.
REQ-029 SHALL verify MULHI and MULLO with A=B=255 -> 8'hFE (MULHI) and 8'h01 (MULLO); MULHI with A=B=200 -> 8'h9C.
REQ-030 SHALL verify DIV, A=100, B=7 -> 8'h0E; MOD, same operands -> 8'h02; DivZero=0 in both cases.
REQ-031 SHALL verify DIV, A=8'h55, B=0 -> Write_Data=8'hFF, DivZero=1; MOD, same operands -> Write_Data=8'h55, DivZero=1.
REQ-032 SHALL verify Start pulsed with new operands during CALC -> ignored, and the original result is written once; back-to-back Start held high -> second op accepted at E10.
REQ-033 SHALL verify RST=0 asserted during the 4th CALC cycle -> outputs 0 immediately, no WriteEN; after release, MULLO 2*3 -> Write_Data=8'h06 after 9 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 8-bit multiply / divide unit with register-file write-back.
// One operation at a time: capture in IDLE, eight iterations in CALC,
// a single write-back cycle in WB, then return to IDLE. Latency is fixed
// regardless of operand values, including divide-by-zero.
module mult_div_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [1:0] Op,
  input  logic [2:0] Dest,
  input  logic [7:0] OperandA,
  input  logic [7:0] OperandB,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero,
  output logic       WriteEN,
  output logic [2:0] Write_Address,
  output logic [7:0] Write_Data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_MOD   = 2'b11;

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [7:0]  opa_r;
  logic [7:0]  opb_r;
  logic [1:0]  op_r;
  logic [2:0]  dest_r;
  logic [15:0] prod_r;
  logic [7:0]  rem_r;
  logic [7:0]  quo_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;
  logic        wen_r;
  logic [2:0]  waddr_r;
  logic [7:0]  wdata_r;

  logic [15:0] prod_add_s;
  logic [15:0] prod_next_s;
  logic [8:0]  rem_shift_s;
  logic [7:0]  rem_next_s;
  logic [7:0]  quo_next_s;
  logic        q_bit_s;
  logic        div_zero_s;
  logic [7:0]  result_s;

  // One shift-add and one restoring-division step for the current counter value,
  // plus selection of the result that the final step would produce.
  always_comb begin
    prod_add_s  = 16'h0000;
    prod_next_s = 16'h0000;
    rem_shift_s = 9'h000;
    rem_next_s  = 8'h00;
    quo_next_s  = 8'h00;
    q_bit_s     = 1'b0;
    div_zero_s  = 1'b0;
    result_s    = 8'h00;

    // Multiplier bit cnt selects the multiplicand shifted into place.
    if (opb_r[cnt_r]) begin
      prod_add_s = {8'h00, opa_r} << cnt_r;
    end else begin
      prod_add_s = 16'h0000;
    end
    prod_next_s = prod_r + prod_add_s;

    // Bring down the next dividend bit, MSB first; subtract if the divisor fits.
    rem_shift_s = {rem_r, opa_r[3'd7 - cnt_r]};
    if (rem_shift_s >= {1'b0, opb_r}) begin
      rem_next_s = rem_shift_s[7:0] - opb_r;
      q_bit_s    = 1'b1;
    end else begin
      rem_next_s = rem_shift_s[7:0];
      q_bit_s    = 1'b0;
    end
    quo_next_s = {quo_r[6:0], q_bit_s};

    div_zero_s = op_r[1] && (opb_r == 8'h00);

    case (op_r)
      OP_MULLO: result_s = prod_next_s[7:0];
      OP_MULHI: result_s = prod_next_s[15:8];
      OP_DIV:   result_s = div_zero_s ? 8'hFF : quo_next_s;
      OP_MOD:   result_s = div_zero_s ? opa_r : rem_next_s;
      default:  result_s = 8'h00;
    endcase
  end

  // Control FSM, datapath registers and registered write-back outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      opa_r      <= 8'h00;
      opb_r      <= 8'h00;
      op_r       <= 2'b00;
      dest_r     <= 3'd0;
      prod_r     <= 16'h0000;
      rem_r      <= 8'h00;
      quo_r      <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      wen_r      <= 1'b0;
      waddr_r    <= 3'd0;
      wdata_r    <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r     <= 1'b0;
          div_zero_r <= 1'b0;
          wen_r      <= 1'b0;
          waddr_r    <= 3'd0;
          wdata_r    <= 8'h00;
          if (Start) begin
            opa_r   <= OperandA;
            opb_r   <= OperandB;
            op_r    <= Op;
            dest_r  <= Dest;
            cnt_r   <= 3'd0;
            prod_r  <= 16'h0000;
            rem_r   <= 8'h00;
            quo_r   <= 8'h00;
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          prod_r <= prod_next_s;
          rem_r  <= rem_next_s;
          quo_r  <= quo_next_s;
          busy_r <= 1'b1;
          if (cnt_r == 3'd7) begin
            // Last step: present the result during the WB cycle.
            wen_r      <= 1'b1;
            done_r     <= 1'b1;
            div_zero_r <= div_zero_s;
            waddr_r    <= dest_r;
            wdata_r    <= result_s;
            state_r    <= ST_WB;
          end else begin
            cnt_r   <= cnt_r + 3'd1;
            state_r <= ST_CALC;
          end
        end
        ST_WB: begin
          wen_r      <= 1'b0;
          done_r     <= 1'b0;
          div_zero_r <= 1'b0;
          waddr_r    <= 3'd0;
          wdata_r    <= 8'h00;
          busy_r     <= 1'b0;
          cnt_r      <= 3'd0;
          state_r    <= ST_IDLE;
        end
        default: begin
          wen_r      <= 1'b0;
          done_r     <= 1'b0;
          div_zero_r <= 1'b0;
          waddr_r    <= 3'd0;
          wdata_r    <= 8'h00;
          busy_r     <= 1'b0;
          cnt_r      <= 3'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy          = busy_r;
  assign Done          = done_r;
  assign DivZero       = div_zero_r;
  assign WriteEN       = wen_r;
  assign Write_Address = waddr_r;
  assign Write_Data    = wdata_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic       CLK;
  logic       RST;
  logic       Start;
  logic [1:0] Op;
  logic [2:0] Dest;
  logic [7:0] OperandA;
  logic [7:0] OperandB;
  logic       Busy;
  logic       Done;
  logic       DivZero;
  logic       WriteEN;
  logic [2:0] Write_Address;
  logic [7:0] Write_Data;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  mult_div_unit dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .Dest(Dest),
    .OperandA(OperandA), .OperandB(OperandB), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .WriteEN(WriteEN), .Write_Address(Write_Address),
    .Write_Data(Write_Data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Run one operation from Start and check every cycle up to the return to IDLE.
  // When inject is set, a second Start with other operands is pulsed mid-CALC.
  task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] d, input logic [7:0] exp_data,
                        input logic exp_dz, input logic inject);
    @(negedge CLK);
    Op = op; OperandA = a; OperandB = b; Dest = d; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK);
      #1;
      if (inject && k == 3) begin
        Start = 1'b1; Op = 2'b00; OperandA = 8'd9; OperandB = 8'd9; Dest = 3'd7;
      end
      if (inject && k == 4) Start = 1'b0;
      if (k < 8) begin
        chk_cnt++;
        if (WriteEN !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0)
          $display("FAIL %s_calc k=%0d: WriteEN=%b Busy=%b Done=%b, required 0/1/0", name, k, WriteEN, Busy, Done);
        else pass_cnt++;
      end else if (k == 8) begin
        chk_cnt++;
        if (WriteEN !== 1'b1 || Done !== 1'b1 || Busy !== 1'b1)
          $display("FAIL %s_wb_ctl: WriteEN=%b Done=%b Busy=%b, required 1/1/1", name, WriteEN, Done, Busy);
        else pass_cnt++;
        chk_cnt++;
        if (Write_Address !== d || Write_Data !== exp_data)
          $display("FAIL %s_wb_data: addr=%0d data=%h, required addr=%0d data=%h", name, Write_Address, Write_Data, d, exp_data);
        else pass_cnt++;
        chk_cnt++;
        if (DivZero !== exp_dz)
          $display("FAIL %s_divzero: DivZero=%b, required %b", name, DivZero, exp_dz);
        else pass_cnt++;
      end else begin
        chk_cnt++;
        if (WriteEN !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0 || Write_Data !== 8'h00 || Write_Address !== 3'd0)
          $display("FAIL %s_idle: WriteEN=%b Done=%b Busy=%b addr=%0d data=%h, required all 0", name, WriteEN, Done, Busy, Write_Address, Write_Data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b0; Op = 2'b00; Dest = 3'd0; OperandA = 8'h00; OperandB = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk_cnt++;
    if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0 || WriteEN !== 1'b0 || Write_Address !== 3'd0 || Write_Data !== 8'h00)
      $display("FAIL reset: Busy=%b Done=%b DivZero=%b WriteEN=%b addr=%0d data=%h, required all 0", Busy, Done, DivZero, WriteEN, Write_Address, Write_Data);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mullo_13x11", 2'b00, 8'd13, 8'd11, 3'd3, 8'h8F, 1'b0, 1'b0);
    run_op("mulhi_255x255", 2'b01, 8'd255, 8'd255, 3'd1, 8'hFE, 1'b0, 1'b0);
    run_op("mullo_255x255", 2'b00, 8'd255, 8'd255, 3'd2, 8'h01, 1'b0, 1'b0);
    run_op("mulhi_200x200", 2'b01, 8'd200, 8'd200, 3'd4, 8'h9C, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_100_7", 2'b10, 8'd100, 8'd7, 3'd5, 8'h0E, 1'b0, 1'b0);
    run_op("mod_100_7", 2'b11, 8'd100, 8'd7, 3'd6, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op("div_55_0", 2'b10, 8'h55, 8'h00, 3'd7, 8'hFF, 1'b1, 1'b0);
    run_op("mod_55_0", 2'b11, 8'h55, 8'h00, 3'd0, 8'h55, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    int extra = 0;
    run_op("ignored_start", 2'b10, 8'd200, 8'd9, 3'd2, 8'd22, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      if (WriteEN === 1'b1) extra++;
    end
    chk_cnt++;
    if (extra !== 0)
      $display("FAIL ignored_start_single_write: extra writes=%0d, required 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int first_edge = -1;
    int second_edge = -1;
    int writes = 0;
    logic [7:0] first_data = 8'h00;
    logic [7:0] second_data = 8'h00;
    logic [2:0] second_addr = 3'd0;
    @(negedge CLK);
    Op = 2'b00; OperandA = 8'd3; OperandB = 8'd5; Dest = 3'd1; Start = 1'b1;
    @(posedge CLK);
    #1;
    OperandA = 8'd4; OperandB = 8'd6; Dest = 3'd2;
    for (int k = 1; k <= 25; k++) begin
      @(posedge CLK);
      #1;
      if (k == 10) Start = 1'b0;
      if (WriteEN === 1'b1) begin
        writes++;
        if (first_edge < 0) begin
          first_edge = k; first_data = Write_Data;
        end else if (second_edge < 0) begin
          second_edge = k; second_data = Write_Data; second_addr = Write_Address;
        end
      end
    end
    chk_cnt++;
    if (first_edge !== 8 || first_data !== 8'd15)
      $display("FAIL b2b_first: edge=%0d data=%h, required edge=8 data=0f", first_edge, first_data);
    else pass_cnt++;
    chk_cnt++;
    if (second_edge !== 18 || second_data !== 8'd24 || second_addr !== 3'd2)
      $display("FAIL b2b_second: edge=%0d data=%h addr=%0d, required edge=18 data=18 addr=2", second_edge, second_data, second_addr);
    else pass_cnt++;
    chk_cnt++;
    if (writes !== 2)
      $display("FAIL b2b_count: writes=%0d, required 2", writes);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    int writes = 0;
    @(negedge CLK);
    Op = 2'b01; OperandA = 8'd200; OperandB = 8'd200; Dest = 3'd6; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_cnt++;
    if (Busy !== 1'b0 || Done !== 1'b0 || WriteEN !== 1'b0 || DivZero !== 1'b0 || Write_Data !== 8'h00 || Write_Address !== 3'd0)
      $display("FAIL reset_mid: Busy=%b Done=%b WriteEN=%b DivZero=%b addr=%0d data=%h, required all 0", Busy, Done, WriteEN, DivZero, Write_Address, Write_Data);
    else pass_cnt++;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      if (WriteEN === 1'b1 || Busy === 1'b1) writes++;
    end
    chk_cnt++;
    if (writes !== 0)
      $display("FAIL reset_mid_abort: active cycles=%0d, required 0", writes);
    else pass_cnt++;
    run_op("after_reset_2x3", 2'b00, 8'd2, 8'd3, 3'd5, 8'h06, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
